// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS opcodes, loader description classes and loader FSM encoding
package mips_isa_pkg;

    // Opcodes shared with the control decoder
    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] LUI    = 6'h0F;
    localparam logic [5:0] ANDI   = 6'h0C;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;

    localparam logic [3:0] K_R    = 4'd0;
    localparam logic [3:0] K_ADDI = 4'd1;
    localparam logic [3:0] K_ORI  = 4'd2;
    localparam logic [3:0] K_LUI  = 4'd3;
    localparam logic [3:0] K_ANDI = 4'd4;
    localparam logic [3:0] K_LW   = 4'd5;
    localparam logic [3:0] K_SW   = 4'd6;
    localparam logic [3:0] K_BEQ  = 4'd7;
    localparam logic [3:0] K_BNE  = 4'd8;
    localparam logic [3:0] K_J    = 4'd9;
    localparam logic [3:0] K_JAL  = 4'd10;
    localparam logic [3:0] K_END  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } loader_state_e;

endpackage

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs one instruction description into a 32-bit MIPS word
module instr_encoder
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // legal_o covers encodable classes only; END is handled by the loader
    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (kind_i)
            K_R:     word_o = {R_TYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
            K_ADDI:  word_o = {ADDI, rs_i, rt_i, imm_i};
            K_ORI:   word_o = {ORI,  rs_i, rt_i, imm_i};
            K_LUI:   word_o = {LUI,  5'd0, rt_i, imm_i};
            K_ANDI:  word_o = {ANDI, rs_i, rt_i, imm_i};
            K_LW:    word_o = {LW,   rs_i, rt_i, imm_i};
            K_SW:    word_o = {SW,   rs_i, rt_i, imm_i};
            K_BEQ:   word_o = {BEQ,  rs_i, rt_i, imm_i};
            K_BNE:   word_o = {BNE,  rs_i, rt_i, imm_i};
            K_J:     word_o = {J,    target_i};
            K_JAL:   word_o = {JAL,  target_i};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams encoded instructions into instruction memory while holding the CPU in reset
module program_loader
    import mips_isa_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR    = 32'h0040_0000,
    localparam int         CW           = $clog2(MEMORY_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_kind,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [5:0]    in_funct,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(MEMORY_DEPTH);

    loader_state_e state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          accept;

    instr_encoder u_encoder (
        .kind_i   (in_kind),
        .rs_i     (in_rs),
        .rt_i     (in_rt),
        .rd_i     (in_rd),
        .shamt_i  (in_shamt),
        .funct_i  (in_funct),
        .imm_i    (in_imm),
        .target_i (in_target),
        .word_o   (enc_word),
        .legal_o  (enc_legal)
    );

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
        count_d     = count_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    in_ready_d = 1'b1;
                    count_d    = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    in_ready_d = 1'b0;
                    if (in_kind == K_END) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if (!enc_legal || count_q == FULL) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d     = S_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + (32'(count_q) << 2);
                        mem_wdata_d = enc_word;
                    end
                end
            end
            S_WRITE: begin
                state_d    = S_LOAD;
                in_ready_d = 1'b1;
                count_d    = count_q + CW'(1);
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;
    assign count     = count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader against a reference model
module tb_program_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam logic [5:0]  OPTAB [11] = '{6'h00, 6'h08, 6'h0D, 6'h0F, 6'h0C,
                                           6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        mem_we, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int m_count = 0;
    int m_state = 0;
    int exp_writes = 0;
    int wr_seen = 0;
    logic [31:0] last_addr, last_wdata;

    program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .count(count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we === 1'b1) wr_seen++;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int k, input int rs, input int rt, input int rd,
                                               input int sh, input int fn, input int imm, input int tgt);
        int unsigned op;
        op = 32'(OPTAB[k]);
        if (k == 0)
            return 32'((rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + fn);
        if (k >= 9)
            return 32'((op << 26) + tgt);
        if (k == 3)
            rs = 0;
        return 32'((op << 26) + (rs << 21) + (rt << 16) + imm);
    endfunction

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_count = 0;
        m_state = 0;
        check("start_ready", 32'(in_ready), 1);
        check("start_hold", 32'(cpu_hold), 1);
        check("start_count", 32'(count), 0);
        check("start_err_done", {30'd0, error, done}, 0);
    endtask

    task automatic send(input int k, input int rs, input int rt, input int rd, input int sh,
                        input int fn, input int imm, input int tgt, input bit hold);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check("ready_wait", 32'(in_ready), 1);
        in_kind = 4'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt);
        in_valid = 1'b1;
        step();
        if (!hold) in_valid = 1'b0;
        if (k == 15) begin
            m_state = 1;
            check("end_done", 32'(done), 1);
            check("end_hold", 32'(cpu_hold), 0);
            check("end_we", 32'(mem_we), 0);
            check("end_count", 32'(count), 32'(m_count));
        end else if (k > 10 || m_count == DEPTH) begin
            m_state = 2;
            check("err_flag", 32'(error), 1);
            check("err_we", 32'(mem_we), 0);
            check("err_hold", 32'(cpu_hold), 1);
            check("err_count", 32'(count), 32'(m_count));
        end else begin
            last_addr = mem_addr;
            last_wdata = mem_wdata;
            check("wr_we", 32'(mem_we), 1);
            check("wr_addr", mem_addr, BASE + 32'(m_count * 4));
            check("wr_data", mem_wdata, model_word(k, rs, rt, rd, sh, fn, imm, tgt));
            check("wr_ready", 32'(in_ready), 0);
            m_count++;
            exp_writes++;
            step();
            in_valid = 1'b0;
            check("post_we", 32'(mem_we), 0);
            check("post_ready", 32'(in_ready), 1);
            check("post_count", 32'(count), 32'(m_count));
            check("post_hold", 32'(cpu_hold), 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_random(input int k, input bit hold);
        send(k, $urandom_range(31), $urandom_range(31), $urandom_range(31), $urandom_range(31),
             $urandom_range(63), $urandom_range(65535), $urandom_range(26'h3FFFFFF), hold);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_funct = '0; in_imm = '0; in_target = '0;
        last_addr = '0; last_wdata = '0;
        step(); step();
        check("rst_ready", 32'(in_ready), 0);
        check("rst_flags", {28'd0, mem_we, cpu_hold, done, error}, 0);
        check("rst_count", 32'(count), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        step();
        check("idle_ready", 32'(in_ready), 0);

        // start together with a valid description: only start acts
        in_kind = 4'd1; in_rt = 5'd8; in_imm = 16'd5;
        in_valid = 1'b1;
        do_start();
        in_valid = 1'b0;
        check("start_not_consumed", 32'(mem_we), 0);
        step();
        check("start_not_consumed2", 32'(mem_we), 0);

        send(1, 0, 8, 0, 0, 0, 5, 0, 0);
        check("addi_addr", last_addr, 32'h0040_0000);
        check("addi_word", last_wdata, 32'h2008_0005);
        check("addi_count", 32'(count), 1);
        send(0, 8, 9, 10, 0, 32'h20, 0, 0, 1);
        check("r_addr", last_addr, 32'h0040_0004);
        check("r_word", last_wdata, 32'h0109_5020);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_load_count", 32'(count), 2);
        check("start_in_load_ready", 32'(in_ready), 1);
        send(3, 3, 1, 0, 0, 0, 32'h1001, 0, 0);
        check("lui_word", last_wdata, 32'h3C01_1001);
        send(15, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        check("done_held", {29'd0, done, cpu_hold, error}, 32'b100);
        check("done_count", 32'(count), 3);

        // overflow session: four writes then a legal fifth
        do_start();
        send(9, 0, 0, 0, 0, 0, 0, 32'h0100000, 1);
        check("j_word", last_wdata, 32'h0810_0000);
        for (int i = 1; i < DEPTH; i++) begin
            send_random($urandom_range(10), i[0]);
            check("ovf_addr", last_addr, 32'h0040_0000 + 32'(i * 4));
        end
        send_random($urandom_range(10), 0);
        step(); step();
        check("ovf_held", {29'd0, error, cpu_hold, mem_we}, 32'b110);
        check("ovf_count", 32'(count), 4);

        // illegal class
        do_start();
        send(12, 1, 2, 3, 4, 5, 6, 7, 0);

        // random sessions
        for (int s = 0; s < 8; s++) begin
            int n;
            do_start();
            n = $urandom_range(5);
            for (int i = 0; i < n && m_state == 0; i++) begin
                if ($urandom_range(7) == 0) send_random($urandom_range(14, 11), 0);
                else send_random($urandom_range(10), $urandom_range(1));
            end
            if (m_state == 0) send_random(15, 0);
        end

        // reset during WRITE with in_valid held
        do_start();
        in_kind = 4'd2; in_valid = 1'b1;
        step();
        exp_writes++;
        check("rw_we", 32'(mem_we), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rw_flags", {29'd0, mem_we, cpu_hold, in_ready}, 0);
        check("rw_count", 32'(count), 0);
        step(); step(); step();
        check("rw_idle", {29'd0, mem_we, in_ready, cpu_hold}, 0);
        in_valid = 1'b0;
        step();
        check("write_total", 32'(wr_seen), 32'(exp_writes));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
